max7219_rx: RTL and testbench
=============================

MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each of sck, din and cs (legal range 2..3).
REQ-002 clk  input  1  system clock; every internal register is clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sck  input  1  serial clock from the MAX7219 driver, asynchronous to clk.
REQ-005 din  input  1  serial data, MSB first, sampled on the rising edge of sck.
REQ-006 cs  input  1  LOAD/CS; low frames a transfer, and its rising edge latches the frame.
REQ-007 rd_addr  input  3  digit select (0 selects digit register 1, 7 selects digit register 8).
REQ-008 rd_data  output  8  segment pattern for rd_addr in order {DP,A,B,C,D,E,F,G}, registered.
REQ-009 intensity  output  4 / scan_limit  output  3 / shutdown  output  1 / disp_test  output  1: current control registers.
REQ-010 frame_valid  output  1  one-cycle pulse when a frame is accepted.
REQ-011 frame_err  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-012 sck, din and cs SHALL each pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized signals only.
REQ-013 Correct operation SHALL be guaranteed when sck high and low times are each at least 3 clk periods and din is stable at least 2 clk periods around each sck rise.
REQ-014 A falling edge on synced cs SHALL clear the 16-bit shift register and the 5-bit bit counter.
REQ-015 While synced cs is low, each synced sck rising edge SHALL shift din into bit 0 of the shift register; the counter SHALL count up and saturate at 17.
REQ-016 A synced sck rise in the same cycle as a synced cs rise SHALL be ignored.
REQ-017 On a synced cs rise with a count of exactly 16, the block SHALL decode the frame: address = bits[11:8], data = bits[7:0], bits[15:12] ignored.
REQ-018 On a synced cs rise with any count other than 16, the block SHALL pulse frame_err in the following cycle and SHALL NOT write any register.
REQ-019 Address writes: 0x0 no-op; 0x1-0x8 digit register; 0x9 decode mode; 0xA intensity (data[3:0]); 0xB scan limit (data[2:0]); 0xC shutdown = !data[0]; 0xF disp_test = data[0]; 0xD and 0xE ignored.
REQ-020 Every accepted frame, including no-op and ignored addresses, SHALL pulse frame_valid in the cycle the register write becomes visible, which is one cycle after the synced cs rise.
REQ-021 rd_data SHALL be registered with 1-cycle latency from rd_addr and from any register change.
REQ-022 rd_data priority: disp_test=1 gives 0xFF; otherwise shutdown=1 gives 0x00; otherwise a digit index greater than scan_limit gives 0x00; otherwise the digit value, decoded per REQ-027.
REQ-023 Writes to the digit register being read SHALL appear on rd_data 2 cycles after the synced cs rise.

Reset
REQ-024 During rst, the following SHALL be forced: digits = 0, decode = 0x00, intensity = 0, scan_limit = 0, shutdown = 1, disp_test = 0, rd_data = 0x00, frame_valid = 0, frame_err = 0, counter = 0, shift register = 0.
REQ-025 Synchronizer flops SHALL reset to sck = 0, din = 0 and cs = 1.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; bits that arrive after rst deasserts and before the next cs falling edge SHALL be ignored.

Configuration
REQ-027 With macro MAX7219_RX_CODEB_EN defined, a digit whose decode bit (n-1) is set SHALL map data[3:0] through Code B, with data[7] passed to DP.
Code B map: 0-9 = 7E,30,6D,79,33,5B,5F,70,7F,7B; A = 01 ('-'); B = 4F (E); C = 37 (H); D = 0E (L); E = 67 (P); F = 00 (blank).
REQ-028 Without MAX7219_RX_CODEB_EN, the decode register SHALL still be writable, but rd_data SHALL always be the raw digit byte.

Verification
REQ-029 After reset, with no traffic: shutdown = 1 and rd_data = 0x00 for every rd_addr, and no frame_valid or frame_err pulse occurs.
REQ-030 Send frames 0x0C01, 0x0B07, 0x0155, then set rd_addr = 0: expect 3 frame_valid pulses, shutdown = 0, scan_limit = 7, and rd_data = 0x55.
REQ-031 Send 0x0C01, 0x0B02, 0x0533, then read rd_addr = 4: expect rd_data = 0x00 (masked by scan limit); send 0x0B07 and expect rd_data = 0x33.
REQ-032 Send a 15-bit frame, then a 17-bit frame, each with address 0x1: expect 2 frame_err pulses and digit register 1 unchanged.
REQ-033 With CODEB_EN defined, send 0x0C01, 0x0B07, 0x09FF, 0x0283, then read rd_addr = 1: expect rd_data = 0xF9.
REQ-034 Assert rst after 8 bits of a frame, then finish the frame and raise cs: expect no write and no frame_valid pulse.

Source files
------------

// File: rtl/max7219_rx.sv
// ============================================================================
// Module      : max7219_rx
// Description : MAX7219-compatible serial receiver with a digit/control
//               register file and registered read-back. Define the macro
//               MAX7219_RX_CODEB_EN to enable Code B decoding on read-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       din,
  input  logic       cs,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       disp_test,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [2:0] SETTLED = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sck_sync, din_sync, cs_sync;
  logic                   sck_s, din_s, cs_s, sck_d, cs_d;
  logic                   sck_rise, cs_rise, cs_fall;
  logic [2:0]             settle;
  logic                   armed;
  logic [15:0]            shreg;
  logic [4:0]             count;
  logic [7:0]             digit [8];
  logic [7:0]             decode;
  logic [7:0]             rd_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      din_sync <= {din_sync[SYNC_STAGES-2:0], din};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // A cs falling edge arms the receiver only once the synchronizers have
  // flushed their reset value, so a frame cut by rst is never resumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_d       <= 1'b0;
      cs_d        <= 1'b1;
      settle      <= '0;
      armed       <= 1'b0;
      shreg       <= '0;
      count       <= '0;
      decode      <= '0;
      intensity   <= '0;
      scan_limit  <= '0;
      shutdown    <= 1'b1;
      disp_test   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < 8; i++) digit[i] <= '0;
    end else begin
      sck_d       <= sck_s;
      cs_d        <= cs_s;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (settle != SETTLED) settle <= settle + 3'd1;

      if (cs_fall && settle == SETTLED) begin
        shreg <= '0;
        count <= '0;
        armed <= 1'b1;
      end else if (cs_rise && armed) begin
        armed <= 1'b0;
        if (count == 5'd16) begin
          frame_valid <= 1'b1;
          case (shreg[11:8])
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: digit[3'(shreg[11:8] - 4'h1)] <= shreg[7:0];
            4'h9:    decode     <= shreg[7:0];
            4'hA:    intensity  <= shreg[3:0];
            4'hB:    scan_limit <= shreg[2:0];
            4'hC:    shutdown   <= ~shreg[0];
            4'hF:    disp_test  <= shreg[0];
            default: ;
          endcase
        end else begin
          frame_err <= 1'b1;
        end
      end else if (armed && !cs_s && sck_rise) begin
        shreg <= {shreg[14:0], din_s};
        if (count != 5'd17) count <= count + 5'd1;
      end
    end
  end

`ifdef MAX7219_RX_CODEB_EN
  function automatic logic [6:0] code_b(input logic [3:0] v);
    case (v)
      4'h0: code_b = 7'h7E;  4'h1: code_b = 7'h30;
      4'h2: code_b = 7'h6D;  4'h3: code_b = 7'h79;
      4'h4: code_b = 7'h33;  4'h5: code_b = 7'h5B;
      4'h6: code_b = 7'h5F;  4'h7: code_b = 7'h70;
      4'h8: code_b = 7'h7F;  4'h9: code_b = 7'h7B;
      4'hA: code_b = 7'h01;  4'hB: code_b = 7'h4F;
      4'hC: code_b = 7'h37;  4'hD: code_b = 7'h0E;
      4'hE: code_b = 7'h67;  default: code_b = 7'h00;
    endcase
  endfunction
  logic unused_bits;
  assign unused_bits = ^shreg[15:12];
`else
  logic unused_bits;
  assign unused_bits = ^{shreg[15:12], decode};
`endif

  always_comb begin
    rd_next = digit[rd_addr];
`ifdef MAX7219_RX_CODEB_EN
    if (decode[rd_addr]) rd_next = {digit[rd_addr][7], code_b(digit[rd_addr][3:0])};
`endif
    if (disp_test)                 rd_next = 8'hFF;
    else if (shutdown)             rd_next = 8'h00;
    else if (rd_addr > scan_limit) rd_next = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= rd_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_max7219_rx.sv
// ============================================================================
// Module      : tb_max7219_rx
// Description : Self-checking bench for max7219_rx against a register-file
//               model (honours MAX7219_RX_CODEB_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max7219_rx;

  logic       clk = 1'b0;
  logic       rst, sck, din, cs;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown, disp_test, frame_valid, frame_err;

  max7219_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .din(din), .cs(cs),
    .rd_addr(rd_addr), .rd_data(rd_data), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown(shutdown), .disp_test(disp_test),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int nv = 0, ne = 0;

  always @(negedge clk) begin
    if (frame_valid) nv++;
    if (frame_err)   ne++;
  end

  // Reference register file
  logic [7:0] m_dig [8];
  logic [7:0] m_dec;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_shut, m_test;

  function automatic logic [7:0] code_b(input logic [3:0] v);
    logic [7:0] tbl [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                             8'h7F, 8'h7B, 8'h01, 8'h4F, 8'h37, 8'h0E, 8'h67, 8'h00};
    return tbl[v];
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    logic [7:0] d;
    if (m_test) return 8'hFF;
    if (m_shut) return 8'h00;
    if (a > int'(m_scan)) return 8'h00;
    d = m_dig[a];
`ifdef MAX7219_RX_CODEB_EN
    if (m_dec[a]) d = {d[7], 7'h00} | code_b(d[3:0]);
`endif
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dec = 8'h00; m_int = 4'h0; m_scan = 3'd0; m_shut = 1'b1; m_test = 1'b0;
  endtask

  task automatic model_write(input logic [15:0] f);
    int a;
    a = int'(f[11:8]);
    if (a >= 1 && a <= 8) m_dig[a-1] = f[7:0];
    else if (a == 9)  m_dec  = f[7:0];
    else if (a == 10) m_int  = f[3:0];
    else if (a == 11) m_scan = f[2:0];
    else if (a == 12) m_shut = ~f[0];
    else if (a == 15) m_test = f[0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] keep;
    keep = rd_addr;
    check({tag, "_intensity"}, 32'(intensity), 32'(m_int));
    check({tag, "_scan"},      32'(scan_limit), 32'(m_scan));
    check({tag, "_shutdown"},  32'(shutdown), 32'(m_shut));
    check({tag, "_disp_test"}, 32'(disp_test), 32'(m_test));
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(exp_rd(a)));
    end
    rd_addr = keep;
    @(negedge clk);
  endtask

  task automatic sck_bit(input logic b);
    din = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] val, input int n);
    int v0, e0, k;
    logic [7:0] old_rd;
    v0 = nv; e0 = ne;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) sck_bit(val[i]);
    repeat (4) @(negedge clk);
    old_rd = exp_rd(int'(rd_addr));
    if (n == 16) model_write(val[15:0]);
    cs = 1'b1;
    k = 0;
    if (n == 16) begin
      while (!frame_valid && k < 20) begin @(negedge clk); k++; end
      check("frame_valid_seen", 32'(frame_valid), 32'd1);
      check("rd_before_write", 32'(rd_data), 32'(old_rd));
      check("int_at_valid", 32'(intensity), 32'(m_int));
      check("shut_at_valid", 32'(shutdown), 32'(m_shut));
      @(negedge clk);
      check("rd_after_write", 32'(rd_data), 32'(exp_rd(int'(rd_addr))));
    end else begin
      while (!frame_err && k < 20) begin @(negedge clk); k++; end
      check("frame_err_seen", 32'(frame_err), 32'd1);
    end
    repeat (6) @(negedge clk);
    check("valid_pulses", 32'(nv - v0), (n == 16) ? 32'd1 : 32'd0);
    check("err_pulses",   32'(ne - e0), (n == 16) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, len;
    logic [15:0] f;
    rst = 1'b1; sck = 1'b0; din = 1'b0; cs = 1'b1; rd_addr = 3'd0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_valid_pulses", 32'(nv), 32'd0);
    check("reset_err_pulses", 32'(ne), 32'd0);
    check("reset_rd", 32'(rd_data), 32'h00);
    check_all("reset");

    // Basic enable, scan limit and digit write
    send(32'h0C01, 16); send(32'h0B07, 16); send(32'h0155, 16);
    rd_addr = 3'd0; @(negedge clk); @(negedge clk);
    check("basic_rd0", 32'(rd_data), 32'h55);
    check_all("basic");

    // Scan-limit masking of digit 5
    send(32'h0C01, 16); send(32'h0B02, 16); send(32'h0533, 16);
    rd_addr = 3'd4; @(negedge clk); @(negedge clk);
    check("scan_masked", 32'(rd_data), 32'h00);
    send(32'h0B07, 16);
    @(negedge clk);
    check("scan_unmasked", 32'(rd_data), 32'h33);

    // Short and long frames are rejected
    send(32'h01AA, 15);
    send(32'h001AA, 17);
    check_all("badlen");

    // Decode-mode read-back of digit 2
    send(32'h0C01, 16); send(32'h0B07, 16); send(32'h09FF, 16); send(32'h0283, 16);
    rd_addr = 3'd1; @(negedge clk); @(negedge clk);
`ifdef MAX7219_RX_CODEB_EN
    check("codeb_rd1", 32'(rd_data), 32'hF9);
`else
    check("raw_rd1", 32'(rd_data), 32'h83);
`endif

    // Reset in the middle of a shutdown-exit frame
    send(32'h0C00, 16);
    v0 = nv;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) sck_bit(1'(8'h0C >> i));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 7; i >= 0; i--) sck_bit(1'(8'h01 >> i));
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_valid_pulses", 32'(nv - v0), 32'd0);
    check_all("midrst");

    // Randomized traffic
    send(32'h0C01, 16);
    for (int t = 0; t < 40; t++) begin
      rd_addr = 3'($urandom_range(0, 7));
      f = 16'($urandom);
      if ($urandom_range(0, 9) == 0) f[11:8] = 4'hF;
      else if (f[11:8] == 4'hF) f[0] = 1'b0;
      len = 16;
      if ($urandom_range(0, 5) == 0) begin
        len = $urandom_range(0, 20);
        if (len == 16) len = 17;
      end
      send({16'h0, f}, len);
      if (t % 10 == 9) check_all($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
